// File: rtl/rc_16_serial_sub.sv
// Digit-serial ripple-borrow subtractor: diff = sum_in - {0,op_in}, DIGIT bits per cycle, LSB first.
// Optional APPROX_LSB_SUB_EN swaps bit 0 for the approximate borrow cell.
module rc_16_serial_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   sum_in,
   input  logic [WIDTH-1:0] op_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   diff_out,
   output logic             underflow
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH:0]   x_r;
   logic [WIDTH-1:0] y_r;
   logic             borrow;
   logic [CNT_W-1:0] cnt;

   logic [DIGIT-1:0] x_dig;
   logic [DIGIT-1:0] y_dig;
   logic [DIGIT-1:0] d_dig;
   logic             borrow_chain;

   // Full-subtractor cell: {borrow_out, difference}
   function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic b);
      sub_cell = {(~x & y) | (~x & b) | (y & b), x ^ y ^ b};
   endfunction

   assign x_dig = x_r[cnt*DIGIT +: DIGIT];
   assign y_dig = y_r[cnt*DIGIT +: DIGIT];

   always_comb begin
      d_dig        = '0;
      borrow_chain = borrow;
      for (int i = 0; i < DIGIT; i++) begin
`ifdef APPROX_LSB_SUB_EN
         // Bit 0 of the whole word never generates a borrow in the approximate build
         if (i == 0 && cnt == '0) begin
            d_dig[i]     = x_dig[i] & ~y_dig[i];
            borrow_chain = 1'b0;
         end else begin
            {borrow_chain, d_dig[i]} = sub_cell(x_dig[i], y_dig[i], borrow_chain);
         end
`else
         {borrow_chain, d_dig[i]} = sub_cell(x_dig[i], y_dig[i], borrow_chain);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff_out  <= '0;
         underflow <= 1'b0;
         borrow    <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_r      <= sum_in;
                  y_r      <= op_in;
                  borrow   <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               diff_out[cnt*DIGIT +: DIGIT] <= d_dig;
               borrow <= borrow_chain;
               cnt    <= cnt + 1'b1;
               // Last digit also resolves the sum's extra top bit against the final borrow
               if (cnt == CNT_W'(N - 1)) begin
                  diff_out[WIDTH] <= x_r[WIDTH] ^ borrow_chain;
                  underflow       <= ~x_r[WIDTH] & borrow_chain;
                  out_valid       <= 1'b1;
                  state           <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rc_16_serial_sub.md
# rc_16_serial_sub

Multi-cycle ripple-borrow subtractor that undoes the 16-bit ripple-carry adder family: given a 17-bit sum and one 16-bit operand, it recovers the other operand. It processes DIGIT bits per clock, LSB first, behind valid/ready handshakes on both sides. It sits downstream of the approximate adders in the characterization datapath, where it reconstructs operands for error/MSE accounting. An optional approximate LSB borrow cell mirrors the approximate LSB adder cell.

## Interface
- WIDTH, 16, operand width; the sum is WIDTH+1 bits.
- DIGIT, 4, bits processed per cycle; WIDTH must be divisible by DIGIT; N = WIDTH/DIGIT.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- sum_in  in  WIDTH+1  minuend (adder output).
- op_in  in  WIDTH  subtrahend (known operand).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- diff_out  out  WIDTH+1  sum_in − {1'b0,op_in}, modulo 2^(WIDTH+1).
- underflow  out  1  final borrow out of bit WIDTH (sum_in < op_in).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch sum_in/op_in, clear the borrow and the digit counter, and go to BUSY. Inputs are ignored at all other times.
- BUSY: each cycle, subtract digit k (bits k·DIGIT .. k·DIGIT+DIGIT−1) with the running borrow, write the result bits, and update the borrow.
  - On the last digit (k=N−1), also compute bit WIDTH = sum bit WIDTH − borrow, and latch underflow = borrow out.
  - Then go to DONE.
- DONE: out_valid=1 and diff_out/underflow are stable. On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle accept-and-return.
- Exact cell per bit: d = x^y^b; bout = (~x&y) | (~x&b) | (y&b).
- diff_out and underflow hold their last values in IDLE until the next result overwrites them.

## Timing
- Reset values: state=IDLE, in_ready=1 in the first cycle after reset, out_valid=0, diff_out=0, underflow=0, borrow=0, counter=0.
- Accept at edge t → digits processed on edges t+1..t+N → out_valid visible after edge t+N. For defaults, that is 4 BUSY cycles.
- Minimum initiation interval: N+2 cycles (accept, N BUSY, ≥1 DONE).
- out_ready held high in DONE → single-cycle DONE, then IDLE.
- out_ready low → DONE persists indefinitely, with outputs frozen.
- Reset asserted in any state → next cycle is IDLE with reset values. In-flight data is discarded and no result is emitted.
- in_valid while BUSY/DONE: not accepted, no effect; the producer must hold it.

## Configuration
- APPROX_LSB_SUB_EN defined: bit 0 uses the approximate cell d0 = x0 & ~y0, with borrow out of bit 0 forced to 0. The rest of the chain is exact. The result is exact+1 when x0=0 and y0=1; otherwise it is exact.
- Undefined: bit 0 uses the exact cell and the block is a bit-exact subtractor.

## Test plan
- Reset then idle: rst high for 2 cycles → out_valid=0, diff_out=0, underflow=0; in_ready=1 in the cycle after rst falls.
- Exact basic: sum_in=0x0_1234, op_in=0x0234 → diff_out=0x01000, underflow=0. out_valid appears exactly 4 cycles after the accept edge (defaults).
- Underflow/wrap: sum_in=0x0_0005, op_in=0x0007 → diff_out=0x1FFFE, underflow=1. sum_in=0x1_FFFE, op_in=0xFFFF → diff_out=0x0FFFF, underflow=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. in_valid pulses during that window are not accepted. Raising out_ready returns to IDLE on the next edge.
- Reset mid-operation: accept sum_in=0x0_00FF, op_in=0x000F, assert rst on the 2nd BUSY cycle → no out_valid ever; next request is processed correctly.
- Approx LSB (macro defined): sum_in=0x0_0002, op_in=0x0001 → diff_out=0x00002 (exact: 0x00001). sum_in=0x0_0003, op_in=0x0001 → diff_out=0x00002. Without the macro, the first case yields 0x00001.
